calc_key_sequencer: RTL
=======================

# calc_key_sequencer

Command-side driver for `calc_top`: buffers host keystrokes in a small FIFO and replays them onto the calculator's 4-bit `cmd` input. Each key is held for a fixed number of cycles, followed by a NOP gap, so that repeated identical keys are separable. Issue is gated on the calculator's `status` (no issue while BUSY), with a BUSY timeout. Sits between the stimulus/host source and `calc_top.cmd`, and consumes `calc_top.status`.

## Interface

- `HOLD_CYCLES`, default 4: cycles a key is driven on `cmd` (≥1).
- `GAP_CYCLES`, default 2: cycles `CMD_NOP` is driven after each key (≥1).
- `DEPTH`, default 8: FIFO entries (power of two, ≥2).
- `TIMEOUT`, default 255: max consecutive BUSY cycles tolerated while a key is pending (≥1).
- `clock  in  1`  single clock; all logic on the rising edge.
- `reset  in  1`  synchronous, active-low.
- `key_in  in  4`  key code from host.
- `key_valid  in  1`  host offers `key_in`.
- `key_ready  out  1`  FIFO not full; transfer when `key_valid && key_ready`.
- `calc_status  in  2`  `calc_top.status`.
- `cmd  out  4`  to `calc_top.cmd`; registered.
- `seq_busy  out  1`  FSM not IDLE or FIFO non-empty.
- `fill  out  $clog2(DEPTH)+1`  FIFO occupancy.
- `timeout_err  out  1`  sticky; BUSY timeout occurred.

## Operation

- Key codes: 0–9 are digits; `CMD_ADD`=A, `CMD_SUB`=B, `CMD_MUL`=C, `CMD_NOP`=D, `CMD_EQ`=E, `CMD_BKSP`=F.
  - Key values are passed through unchecked; `CMD_NOP` is enqueued and driven like any key.
- Status codes: `ST_ERR`=0, `ST_READY`=1, `ST_BUSY`=2. Code 3 is treated as BUSY.
- FIFO:
  - Push on `key_valid && key_ready`; pop on IDLE/STALL→DRIVE.
  - Simultaneous push and pop: `fill` unchanged. A push while full is impossible (`key_ready`=0).
  - Pointers wrap modulo `DEPTH`.
- FSM states: IDLE, STALL, DRIVE, GAP.
  - IDLE: if FIFO is empty, stay. If non-empty and status ≠ BUSY, go to DRIVE and load `cmd` with the FIFO head. If non-empty and BUSY, go to STALL with `stall_cnt`=1.
  - STALL: if status ≠ BUSY, go to DRIVE (pop, load `cmd`). Otherwise, if `stall_cnt`==`TIMEOUT`, flush the FIFO, set `timeout_err`, and go to IDLE. Otherwise increment `stall_cnt`.
  - DRIVE: hold `cmd` for `HOLD_CYCLES` cycles, then go to GAP with `cmd`=`CMD_NOP`.
  - GAP: hold `CMD_NOP` for `GAP_CYCLES` cycles, then go to IDLE.
- ST_ERR does not block issue; the host decides recovery (e.g. sending `CMD_BKSP`).
- `timeout_err` clears only on reset.
- Flush on timeout takes priority over a same-cycle push; that push is dropped.

## Timing

- Reset values: `cmd`=`CMD_NOP`, `fill`=0, `key_ready`=1, `seq_busy`=0, `timeout_err`=0, FSM=IDLE.
- Reset asserted mid-DRIVE or mid-GAP: at the next edge `cmd`=`CMD_NOP` and the FIFO is emptied.
- `key_ready` is a combinational function of `fill` only (`fill` < `DEPTH`); it does not depend on `key_valid`.
- Latency, with status not BUSY and FIFO empty: key accepted at edge 0 → `cmd` = key after edge 1.
- Back-to-back keys: issue period = `HOLD_CYCLES` + `GAP_CYCLES` + 1 cycles (the IDLE decision cycle included).
- `calc_status` is sampled only in IDLE and STALL; it is ignored during DRIVE and GAP.
- Timeout: BUSY on `TIMEOUT` consecutive sampled cycles (IDLE entry counts as 1) → flush at the edge where the count is reached.

## Structure

- `calc_pkg`: key-code and status-code localparams (`CMD_*`, `ST_*`) and the FSM state enum typedef. Shared with `calc_top`.
- Sub-module `key_fifo`:
  - parameter `DEPTH`; 4-bit data.
  - ports: push, pop, flush, `dout`, `fill`, `full`, `empty`.
  - synchronous active-low reset.
- Top holds the FSM, `hold_cnt`, `stall_cnt` and the `cmd` register.

## Test plan

- Single key: after reset, push 4'd7 with status READY → `cmd`=7 for 4 cycles starting 2 cycles after acceptance, then D for 2 cycles; `fill` returns to 0.
- Burst: push 1, 2, A, 3, E back-to-back → `cmd` shows 1,2,A,3,E in order, each as 4 cycles + 3 cycles of D (the 2 GAP cycles plus the IDLE decision cycle, in which `cmd` holds D).
- Repeated key: push 5, 5 → two separate 4-cycle pulses of 5 with D between them.
- Stall: status BUSY for 10 cycles with one key pending → `cmd` stays D. Release to READY → key driven on the following edge; `timeout_err`=0.
- Timeout (`TIMEOUT`=8): status held BUSY with 3 keys queued → after 8 cycles `fill`=0 and `timeout_err`=1; `cmd` never leaves D.
- Full FIFO plus reset: hold status BUSY, push 8 keys → `key_ready`=0 and the 9th push is ignored. Release BUSY, then assert reset during DRIVE → next edge `cmd`=D, `fill`=0, `key_ready`=1.

Source files
------------

// File: rtl/calc_pkg.sv
// Key/status codes and sequencer state shared with calc_top.
// The sequencer treats both status codes with bit 1 set as BUSY.
package calc_pkg;

  localparam logic [3:0] CMD_ADD  = 4'hA;
  localparam logic [3:0] CMD_SUB  = 4'hB;
  localparam logic [3:0] CMD_MUL  = 4'hC;
  localparam logic [3:0] CMD_NOP  = 4'hD;
  localparam logic [3:0] CMD_EQ   = 4'hE;
  localparam logic [3:0] CMD_BKSP = 4'hF;

  localparam logic [1:0] ST_ERR   = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_STALL,
    SEQ_DRIVE,
    SEQ_GAP
  } seq_state_t;

  // codes 2 and 3 both block issue
  function automatic logic st_is_busy(
    input logic [1:0] st
  );
    return st[1];
  endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Host keystroke handshake into the key sequencer.
// Master is the host, slave is the sequencer.
interface calc_key_sequencer_if;

  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_in,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_in,
    input  key_valid,
    output key_ready
  );

endinterface

// File: rtl/calc_key_sequencer_fifo.sv
// Small keystroke FIFO with flush; pointers wrap modulo DEPTH.
// Flush wins over any same-cycle push or pop.
module key_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [3:0]             din,
  output logic [3:0]             dout,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_fill;

  logic w_push;
  logic w_pop;

  assign full  = (r_fill == (AW+1)'(DEPTH));
  assign empty = (r_fill == '0);
  assign fill  = r_fill;
  assign dout  = r_mem[r_rd];

  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (AW+1)'(1);
        2'b01:   r_fill <= r_fill - (AW+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Replays buffered host keys onto calc_top.cmd as HOLD-cycle
// pulses separated by NOP gaps, gated on calc_top.status.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  calc_key_sequencer_if.slave    kif,
  input  logic [1:0]             calc_status,
  output logic [3:0]             cmd,
  output logic                   seq_busy,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   timeout_err
);

  localparam int HMAX =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int HW = $clog2(HMAX + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  seq_state_t    r_state;
  logic [3:0]    r_cmd;
  logic [HW-1:0] r_hold_cnt;
  logic [SW-1:0] r_stall_cnt;
  logic          r_timeout_err;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic                   w_busy;
  logic [3:0]             w_dout;
  logic [$clog2(DEPTH):0] w_fill;
  logic                   w_full;
  logic                   w_empty;

  assign w_busy        = st_is_busy(calc_status);
  assign kif.key_ready = !w_full;
  assign w_push        = kif.key_valid && !w_full;

  assign cmd         = r_cmd;
  assign fill        = w_fill;
  assign timeout_err = r_timeout_err;
  assign seq_busy    = (r_state != SEQ_IDLE) || !w_empty;

  // status only matters while a key is waiting to issue
  always_comb begin
    w_pop   = 1'b0;
    w_flush = 1'b0;
    unique case (r_state)
      SEQ_IDLE: begin
        w_pop = !w_empty && !w_busy;
      end
      SEQ_STALL: begin
        w_pop   = !w_busy;
        w_flush = w_busy &&
                  (r_stall_cnt == SW'(TIMEOUT));
      end
      default: begin
        w_pop   = 1'b0;
        w_flush = 1'b0;
      end
    endcase
  end

  key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (kif.key_in),
    .dout  (w_dout),
    .fill  (w_fill),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= SEQ_IDLE;
      r_cmd         <= CMD_NOP;
      r_hold_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      unique case (r_state)
        SEQ_IDLE: begin
          if (w_pop) begin
            r_state    <= SEQ_DRIVE;
            r_cmd      <= w_dout;
            r_hold_cnt <= HW'(1);
          end else if (!w_empty) begin
            r_state     <= SEQ_STALL;
            r_stall_cnt <= SW'(1);
          end
        end
        SEQ_STALL: begin
          if (w_pop) begin
            r_state    <= SEQ_DRIVE;
            r_cmd      <= w_dout;
            r_hold_cnt <= HW'(1);
          end else if (w_flush) begin
            r_state       <= SEQ_IDLE;
            r_timeout_err <= 1'b1;
          end else begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
          end
        end
        SEQ_DRIVE: begin
          if (r_hold_cnt == HW'(HOLD_CYCLES)) begin
            r_state    <= SEQ_GAP;
            r_cmd      <= CMD_NOP;
            r_hold_cnt <= HW'(1);
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        SEQ_GAP: begin
          if (r_hold_cnt == HW'(GAP_CYCLES)) begin
            r_state <= SEQ_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: begin
          r_state <= SEQ_IDLE;
          r_cmd   <= CMD_NOP;
        end
      endcase
    end
  end

endmodule
